// File: rtl/imem_rsp.sv
`timescale 1ns/1ps
// Instruction memory responder.
// Fetch requests are range-checked and turned into synchronous SRAM reads.
// Each accepted request passes through a one-stage pipeline into an in-order
// response FIFO. Misaligned or out-of-range fetches skip the SRAM read and
// return a bus-error response whose data is zero.
module imem_rsp #(
    parameter logic [31:0] C_ADDR_BASE    = 32'h0000_0000,
    parameter int          C_MEM_SZX      = 10,
    parameter int          C_FIFO_DEPTH_X = 2
) (
    input  logic                 clk_i,
    input  logic                 resetb_i,
    input  logic                 clk_en_i,
    input  logic                 ireqvalid_i,
    output logic                 ireqready_o,
    input  logic [1:0]           ireqhpl_i,
    input  logic [31:0]          ireqaddr_i,
    output logic                 irspvalid_o,
    input  logic                 irspready_i,
    output logic                 irsprerr_o,
    output logic [31:0]          irspdata_o,
    output logic                 mem_rd_o,
    output logic [C_MEM_SZX-1:0] mem_addr_o,
    input  logic [31:0]          mem_rdata_i
);

    localparam int              DEPTH     = 1 << C_FIFO_DEPTH_X;
    localparam int              PW        = C_FIFO_DEPTH_X + 1;
    localparam logic [PW-1:0]   CNT_FULL  = PW'(DEPTH);
    localparam logic [PW-1:0]   ONE       = PW'(1);
    localparam logic [31:0]     MEM_WORDS = 32'd1 << C_MEM_SZX;

    // cnt_q covers both the pipeline stage and the FIFO, so bounding it
    // at DEPTH keeps the FIFO from ever overflowing.
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [32:0]   fifo_q [DEPTH];
    logic          p_valid_q;
    logic          p_err_q;

    logic [31:0]   off;
    logic [31:0]   word_idx;
    logic          in_range;
    logic          accept;
    logic          pop;
    logic          empty;
    logic [32:0]   head;
    logic          unused_hpl;

    // An address below the base wraps to a huge offset and fails the limit.
    assign off      = ireqaddr_i - C_ADDR_BASE;
    assign word_idx = off >> 2;
    assign in_range = (ireqaddr_i[1:0] == 2'b00) && (word_idx < MEM_WORDS);

    // Ready depends only on registered occupancy, never on irspready_i.
    assign ireqready_o = resetb_i & clk_en_i & (cnt_q != CNT_FULL);
    assign accept      = ireqvalid_i & ireqready_o & clk_en_i;

    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign irspvalid_o = clk_en_i & ~empty;
    assign pop         = irspvalid_o & irspready_i & clk_en_i;

    // Outputs are forced to zero when nothing is queued so that stale FIFO
    // contents never show after reset.
    assign head       = fifo_q[rd_ptr_q[PW-2:0]];
    assign irspdata_o = empty ? 32'h0 : head[31:0];
    assign irsprerr_o = ~empty & head[32];

    assign mem_rd_o   = accept & in_range;
    assign mem_addr_o = mem_rd_o ? word_idx[C_MEM_SZX-1:0] : '0;

    // Privilege level is accepted but has no effect on the fetch.
    assign unused_hpl = ^ireqhpl_i;

    // Response storage: the pipeline entry lands here one enabled edge after accept.
    always_ff @(posedge clk_i) begin
        if (clk_en_i && p_valid_q) begin
            fifo_q[wr_ptr_q[PW-2:0]] <= {p_err_q, (p_err_q ? 32'h0 : mem_rdata_i)};
        end
    end

    // Pipeline stage, FIFO pointers and occupancy count.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            p_valid_q <= 1'b0;
            p_err_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
        end else if (clk_en_i) begin
            p_valid_q <= accept;
            p_err_q   <= accept & ~in_range;
            if (p_valid_q) begin
                wr_ptr_q <= wr_ptr_q + ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ONE;
            end
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + ONE;
                2'b01:   cnt_q <= cnt_q - ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_rsp.sv
`timescale 1ns/1ps
// Bench for imem_rsp: directed boundary cases with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_imem_rsp;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          SZX   = 10;
    localparam int          DEPTH = 4;
    localparam int          WORDS = 1 << SZX;

    logic            clk_i       = 1'b0;
    logic            resetb_i    = 1'b1;
    logic            clk_en_i    = 1'b1;
    logic            ireqvalid_i = 1'b0;
    logic            irspready_i = 1'b0;
    logic [1:0]      ireqhpl_i   = 2'b00;
    logic [31:0]     ireqaddr_i  = 32'h0;
    logic [31:0]     mem_rdata_i = 32'h0;
    logic            ireqready_o;
    logic            irspvalid_o;
    logic            irsprerr_o;
    logic [31:0]     irspdata_o;
    logic            mem_rd_o;
    logic [SZX-1:0]  mem_addr_o;

    logic [31:0] sram [WORDS];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          age;
        logic        err;
        logic [31:0] data;
    } ent_t;

    ent_t exp_q[$];
    ent_t ent;
    bit   m_acc, m_pop, head_vis, e_ready, e_valid, e_rd;
    int   nrsp, nacc;

    imem_rsp #(
        .C_ADDR_BASE    (BASE),
        .C_MEM_SZX      (SZX),
        .C_FIFO_DEPTH_X (2)
    ) dut (
        .clk_i       (clk_i),
        .resetb_i    (resetb_i),
        .clk_en_i    (clk_en_i),
        .ireqvalid_i (ireqvalid_i),
        .ireqready_o (ireqready_o),
        .ireqhpl_i   (ireqhpl_i),
        .ireqaddr_i  (ireqaddr_i),
        .irspvalid_o (irspvalid_o),
        .irspready_i (irspready_i),
        .irsprerr_o  (irsprerr_o),
        .irspdata_o  (irspdata_o),
        .mem_rd_o    (mem_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous SRAM: data one cycle after the strobe, held otherwise.
    always @(posedge clk_i) begin
        if (mem_rd_o) mem_rdata_i <= sram[mem_addr_o];
    end

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return (a[1:0] == 2'b00) && ((o >> 2) < 32'(WORDS));
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a - BASE) >> 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: every accepted fetch is queued in order and becomes visible
    // after two enabled edges (the accepting edge plus the pipeline edge).
    always @(posedge clk_i) begin
        if (!resetb_i) begin
            exp_q.delete();
        end else if (clk_en_i) begin
            m_acc = ireqvalid_i && (exp_q.size() != DEPTH);
            m_pop = 1'b0;
            if (exp_q.size() > 0) m_pop = irspready_i && (exp_q[0].age >= 2);
            if (m_pop) void'(exp_q.pop_front());
            foreach (exp_q[i]) exp_q[i].age++;
            if (m_acc) begin
                ent.age  = 1;
                ent.err  = !in_rng(ireqaddr_i);
                ent.data = ent.err ? 32'h0 : sram[word_of(ireqaddr_i)];
                exp_q.push_back(ent);
            end
        end
    end

    // Compare DUT outputs with the model every cycle, away from the clock edge.
    always @(negedge clk_i) begin
        head_vis = 1'b0;
        if (exp_q.size() > 0) head_vis = (exp_q[0].age >= 2);
        e_ready = resetb_i && clk_en_i && (exp_q.size() != DEPTH);
        e_valid = resetb_i && clk_en_i && head_vis;
        e_rd    = e_ready && ireqvalid_i && in_rng(ireqaddr_i);
        chk("m_ready", 32'(ireqready_o), 32'(e_ready));
        chk("m_valid", 32'(irspvalid_o), 32'(e_valid));
        chk("m_rd",    32'(mem_rd_o),    32'(e_rd));
        if (e_rd) chk("m_addr", 32'(mem_addr_o), word_of(ireqaddr_i));
        if (e_valid) begin
            chk("m_data", irspdata_o, exp_q[0].data);
            chk("m_err",  32'(irsprerr_o), 32'(exp_q[0].err));
        end
        if (!resetb_i) begin
            chk("m_rst_data", irspdata_o, 32'h0);
            chk("m_rst_err",  32'(irsprerr_o), 32'h0);
            chk("m_rst_addr", 32'(mem_addr_o), 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch_one(input logic [31:0] a, input logic e_rdv, input logic [31:0] e_idx,
                             input logic [31:0] e_data, input logic e_err);
        irspready_i = 1'b1;
        ireqvalid_i = 1'b1;
        ireqaddr_i  = a;
        @(negedge clk_i);
        chk("d_rd", 32'(mem_rd_o), 32'(e_rdv));
        if (e_rdv) chk("d_addr", 32'(mem_addr_o), e_idx);
        tick();
        ireqvalid_i = 1'b0;
        @(negedge clk_i);
        chk("d_lat1_valid", 32'(irspvalid_o), 32'h0);
        tick();
        @(negedge clk_i);
        chk("d_lat2_valid", 32'(irspvalid_o), 32'h1);
        chk("d_data", irspdata_o, e_data);
        chk("d_err", 32'(irsprerr_o), 32'(e_err));
        tick();
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) sram[i] = $urandom;
        sram[2] = 32'hDEAD_BEEF;
        #2 resetb_i = 1'b0;
        repeat (3) tick();
        resetb_i = 1'b1;
        @(negedge clk_i);
        chk("rel_ready", 32'(ireqready_o), 32'h1);
        tick();

        // Single fetches, including the last word and both error kinds.
        fetch_one(32'h0000_0008, 1'b1, 32'd2, 32'hDEAD_BEEF, 1'b0);
        fetch_one(32'h0000_0FFC, 1'b1, 32'd1023, sram[1023], 1'b0);
        fetch_one(32'h0000_0002, 1'b0, 32'd0, 32'h0, 1'b1);
        fetch_one(BASE + 32'(4 * WORDS), 1'b0, 32'd0, 32'h0, 1'b1);

        // Back-to-back sequential fetches with the consumer always ready.
        nrsp = 0;
        irspready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ireqvalid_i = 1'b1;
            ireqaddr_i  = 32'(i) << 2;
            @(negedge clk_i);
            chk("b2b_ready", 32'(ireqready_o), 32'h1);
            if (irspvalid_o) nrsp++;
            tick();
        end
        ireqvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (irspvalid_o) nrsp++;
            tick();
        end
        chk("b2b_count", 32'(nrsp), 32'd16);

        // Backpressure: only DEPTH requests fit, ready returns a cycle after a pop.
        nacc = 0;
        irspready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ireqvalid_i = 1'b1;
            ireqaddr_i  = 32'h100 + (32'(i) << 2);
            @(negedge clk_i);
            if (ireqready_o) nacc++;
            tick();
        end
        chk("bp_accepted", 32'(nacc), 32'd4);
        @(negedge clk_i);
        chk("bp_full_ready", 32'(ireqready_o), 32'h0);
        tick();
        irspready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_pop_valid", 32'(irspvalid_o), 32'h1);
        chk("bp_pop_ready", 32'(ireqready_o), 32'h0);
        chk("bp_pop_data", irspdata_o, sram[32'h100 >> 2]);
        tick();
        irspready_i = 1'b0;
        @(negedge clk_i);
        chk("bp_ready_back", 32'(ireqready_o), 32'h1);
        tick();
        ireqvalid_i = 1'b0;
        irspready_i = 1'b1;
        repeat (8) tick();

        // Reset with responses queued.
        irspready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ireqvalid_i = 1'b1;
            ireqaddr_i  = 32'h200 + (32'(i) << 2);
            tick();
        end
        ireqvalid_i = 1'b0;
        repeat (3) tick();
        @(negedge clk_i);
        chk("rq_valid_before", 32'(irspvalid_o), 32'h1);
        tick();
        resetb_i    = 1'b0;
        ireqvalid_i = 1'b1;
        @(negedge clk_i);
        chk("rq_ready", 32'(ireqready_o), 32'h0);
        chk("rq_valid", 32'(irspvalid_o), 32'h0);
        chk("rq_err",   32'(irsprerr_o),  32'h0);
        chk("rq_data",  irspdata_o,       32'h0);
        chk("rq_rd",    32'(mem_rd_o),    32'h0);
        chk("rq_addr",  32'(mem_addr_o),  32'h0);
        tick();
        resetb_i    = 1'b1;
        ireqvalid_i = 1'b0;
        irspready_i = 1'b1;
        @(negedge clk_i);
        chk("rq_rel_ready", 32'(ireqready_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("rq_no_stale", 32'(irspvalid_o), 32'h0);
            tick();
        end

        // Randomized traffic with clock-enable gaps.
        for (int c = 0; c < 10000; c++) begin
            int r;
            clk_en_i    = ($urandom_range(0, 9) != 0);
            ireqvalid_i = ($urandom_range(0, 2) != 0);
            irspready_i = ($urandom_range(0, 3) != 0);
            ireqhpl_i   = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 15);
            if (r == 0)      ireqaddr_i = $urandom;
            else if (r == 1) ireqaddr_i = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
            else             ireqaddr_i = 32'($urandom_range(0, WORDS - 1)) << 2;
            tick();
        end
        clk_en_i    = 1'b1;
        ireqvalid_i = 1'b0;
        irspready_i = 1'b1;
        repeat (10) tick();
        @(negedge clk_i);
        chk("end_drained", 32'(irspvalid_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
